// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the management-SPI configuration register file.
package spi_cfg_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } spi_state_e;

    // STATUS bit positions
    localparam int STAT_CS   = 0;
    localparam int STAT_RD   = 1;
    localparam int STAT_WR   = 2;
    localparam int STAT_PEND = 3;
    localparam int STAT_ERR  = 4;

    // CTRL field positions
    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_MODE_W   = 2;
    localparam int CTRL_HOST_SEL = 2;

    // First byte of range r start address (MSB first)
    function automatic int range_start_addr(input int r, input int nb);
        return r * 2 * nb;
    endfunction

    // First byte of range r end address (MSB first)
    function automatic int range_end_addr(input int r, input int nb);
        return r * 2 * nb + nb;
    endfunction

    // CTRL sits right after the range block; RANGE_EN, RANGE_SEL, STATUS follow
    function automatic int ctrl_addr(input int num_ranges, input int nb);
        return 2 * nb * num_ranges;
    endfunction

endpackage

// File: rtl/spi_cfg_regfile_spi_pin_sync.sv
// Synchronises the management SPI pins into clk and derives edge strobes.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mgmt_clk,
    input  logic mgmt_cs_n,
    input  logic mgmt_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_assert,
    output logic cs_release,
    output logic cs_active,
    output logic mosi_s
);

    // Index SYNC_STAGES is a history flop behind the last synchroniser stage,
    // used only for edge detection.
    logic [SYNC_STAGES:0]   clk_pipe;
    logic [SYNC_STAGES:0]   cs_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;

    // Synchroniser chains; CS resets to the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_pipe  <= '0;
            cs_pipe   <= '1;
            mosi_pipe <= '0;
        end else begin
            clk_pipe  <= {clk_pipe[SYNC_STAGES-1:0], mgmt_clk};
            cs_pipe   <= {cs_pipe[SYNC_STAGES-1:0], mgmt_cs_n};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mgmt_mosi};
        end
    end

    assign sclk_rise  =  clk_pipe[SYNC_STAGES-1] & ~clk_pipe[SYNC_STAGES];
    assign sclk_fall  = ~clk_pipe[SYNC_STAGES-1] &  clk_pipe[SYNC_STAGES];
    assign cs_assert  = ~cs_pipe[SYNC_STAGES-1]  &  cs_pipe[SYNC_STAGES];
    assign cs_release =  cs_pipe[SYNC_STAGES-1]  & ~cs_pipe[SYNC_STAGES];
    assign cs_active  = ~cs_pipe[SYNC_STAGES-1];
    assign mosi_s     =  mosi_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/spi_cfg_regfile.sv
// Management-SPI configuration register file with shadowed, atomic commit.
module spi_cfg_regfile
    import spi_cfg_pkg::*;
#(
    parameter int NUM_RANGES   = 2,
    parameter int FLASH_ADDR_W = 24,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mgmt_clk,
    input  logic                               mgmt_cs_n,
    input  logic                               mgmt_mosi,
    output logic                               mgmt_miso,
    output logic [NUM_RANGES*FLASH_ADDR_W-1:0] range_start,
    output logic [NUM_RANGES*FLASH_ADDR_W-1:0] range_end,
    output logic [NUM_RANGES-1:0]              range_enable,
    output logic [NUM_RANGES-1:0]              range_flash_select,
    output logic [7:0]                         control_reg,
    output logic [7:0]                         status_reg,
    output logic                               cfg_update
);

    localparam int         NB     = FLASH_ADDR_W / 8;
    localparam int         NRB    = 2 * NB * NUM_RANGES;
    localparam logic [7:0] A_CTRL = 8'(ctrl_addr(NUM_RANGES, NB));
    localparam logic [7:0] A_EN   = A_CTRL + 8'd1;
    localparam logic [7:0] A_SEL  = A_CTRL + 8'd2;
    localparam logic [7:0] A_STAT = A_CTRL + 8'd3;

    logic sclk_rise, sclk_fall, cs_assert, cs_release, cs_active, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .mgmt_clk   (mgmt_clk),
        .mgmt_cs_n  (mgmt_cs_n),
        .mgmt_mosi  (mgmt_mosi),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .cs_assert  (cs_assert),
        .cs_release (cs_release),
        .cs_active  (cs_active),
        .mosi_s     (mosi_s)
    );

    spi_state_e             state, state_nxt;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift_in;
    logic [7:0]             byte_val, ptr, rd_addr, rd_data, miso_sr;
    logic                   byte_done, is_rd, is_wr, pending, err;
    logic [NRB-1:0][7:0]    rng_sh, rng_cm;
    logic [7:0]             ctrl_sh;
    logic [NUM_RANGES-1:0]  en_sh, sel_sh;

    // cs_active is already low in the release cycle, so a coincident rise is dropped
    assign byte_val  = {shift_in, mosi_s};
    assign byte_done = sclk_rise & cs_active & (bit_cnt == 3'd7);

    // Bit assembly; a released CS discards any partial byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            shift_in <= '0;
        end else if (!cs_active) begin
            bit_cnt  <= '0;
        end else if (sclk_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= byte_val[6:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; CS release overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cs_assert) state_nxt = ST_CMD;
            ST_CMD:   if (byte_done)
                          state_nxt = (byte_val == CMD_WRITE || byte_val == CMD_READ) ? ST_ADDR : ST_IGNORE;
            ST_ADDR:  if (byte_done) state_nxt = is_rd ? ST_RDATA : ST_WDATA;
            default:  ;
        endcase
        if (cs_release) state_nxt = ST_IDLE;
    end

    // Live status word
    always_comb begin
        status_reg            = '0;
        status_reg[STAT_CS]   = cs_active;
        status_reg[STAT_RD]   = is_rd;
        status_reg[STAT_WR]   = is_wr;
        status_reg[STAT_PEND] = pending;
        status_reg[STAT_ERR]  = err;
    end

    // Read mux over the committed view. The command bits of STATUS are masked
    // on the wire: an SPI read of STATUS is always a read command, so they
    // carry nothing and would only obscure the cs/pending/err value.
    assign rd_addr = (state == ST_ADDR) ? byte_val : ptr;
    always_comb begin
        rd_data = 8'hFF;
        for (int i = 0; i < NRB; i++)
            if (rd_addr == 8'(i)) rd_data = rng_cm[i];
        if (rd_addr == A_CTRL) rd_data = control_reg;
        if (rd_addr == A_EN)   rd_data = 8'(range_enable);
        if (rd_addr == A_SEL)  rd_data = 8'(range_flash_select);
        if (rd_addr == A_STAT) begin
            rd_data          = status_reg;
            rd_data[STAT_RD] = 1'b0;
            rd_data[STAT_WR] = 1'b0;
        end
    end

    // Transaction datapath: pointer, shadow staging, read loads and atomic commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr                <= '0;
            miso_sr            <= '0;
            is_rd              <= 1'b0;
            is_wr              <= 1'b0;
            pending            <= 1'b0;
            err                <= 1'b0;
            cfg_update         <= 1'b0;
            rng_sh             <= '1;
            rng_cm             <= '1;
            ctrl_sh            <= '0;
            en_sh              <= '0;
            sel_sh             <= '0;
            control_reg        <= '0;
            range_enable       <= '0;
            range_flash_select <= '0;
        end else begin
            cfg_update <= 1'b0;
            if (cs_release) begin
                is_rd <= 1'b0;
                is_wr <= 1'b0;
                if (pending) begin
                    rng_cm             <= rng_sh;
                    control_reg        <= ctrl_sh;
                    range_enable       <= en_sh;
                    range_flash_select <= sel_sh;
                    cfg_update         <= 1'b1;
                    pending            <= 1'b0;
                end
            end else if (byte_done) begin
                case (state)
                    ST_CMD: begin
                        is_wr <= (byte_val == CMD_WRITE);
                        is_rd <= (byte_val == CMD_READ);
                    end
                    ST_ADDR: begin
                        if (is_rd) begin
                            miso_sr <= rd_data;
                            ptr     <= byte_val + 8'd1;
                            if (byte_val == A_STAT) err <= 1'b0;
                        end else begin
                            ptr <= byte_val;
                        end
                    end
                    ST_RDATA: begin
                        miso_sr <= rd_data;
                        ptr     <= ptr + 8'd1;
                        if (ptr == A_STAT) err <= 1'b0;
                    end
                    ST_WDATA: begin
                        for (int i = 0; i < NRB; i++)
                            if (ptr == 8'(i)) rng_sh[i] <= byte_val;
                        if (ptr == A_CTRL) ctrl_sh <= byte_val;
                        if (ptr == A_EN)   en_sh   <= byte_val[NUM_RANGES-1:0];
                        if (ptr == A_SEL)  sel_sh  <= byte_val[NUM_RANGES-1:0];
                        if (ptr >= A_STAT) err     <= 1'b1;
                        pending <= 1'b1;
                        ptr     <= ptr + 8'd1;
                    end
                    default: ;
                endcase
            end else if (sclk_fall && state == ST_RDATA) begin
                miso_sr <= {miso_sr[6:0], 1'b0};
            end
        end
    end

    // MISO driver: only shifts out during RDATA, otherwise forced low
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   mgmt_miso <= 1'b0;
        else if (cs_release || state != ST_RDATA)  mgmt_miso <= 1'b0;
        else if (sclk_fall)                        mgmt_miso <= miso_sr[7];
    end

    // Unpack committed byte array onto the range buses, MSB byte first
    always_comb begin
        range_start = '0;
        range_end   = '0;
        for (int r = 0; r < NUM_RANGES; r++) begin
            for (int b = 0; b < NB; b++) begin
                range_start[r*FLASH_ADDR_W + (NB-1-b)*8 +: 8] = rng_cm[range_start_addr(r, NB) + b];
                range_end[r*FLASH_ADDR_W + (NB-1-b)*8 +: 8]   = rng_cm[range_end_addr(r, NB) + b];
            end
        end
    end

endmodule

// File: doc/spi_cfg_regfile.md
Name: spi_cfg_regfile

Overview:
- Parametrised successor to the management-SPI configuration slave.
- Runs entirely in the system clock domain: mgmt SPI pins are oversampled; there is no SPI-clocked logic.
- Holds NUM_RANGES flash address windows plus control/enable/select registers. Supports burst auto-increment reads and writes.
- Multi-byte writes are staged in shadow registers and committed atomically on CS release, so the RAID router never sees a half-written range.

Parameters:
- NUM_RANGES, 2, number of address windows (1..8).
- FLASH_ADDR_W, 24, width of each start/end address; multiple of 8, 8..32. NB = FLASH_ADDR_W/8.
- SYNC_STAGES, 2, synchroniser depth on mgmt_clk/mgmt_cs_n/mgmt_mosi (>=2).

Ports:
- clk  in  1  system clock; must be >= 4x mgmt_clk frequency.
- rst  in  1  reset.
- mgmt_clk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- mgmt_cs_n  in  1  chip select, active low.
- mgmt_mosi  in  1  serial data in, MSB first.
- mgmt_miso  out  1  serial data out, registered.
- range_start  out  NUM_RANGES*FLASH_ADDR_W  committed start addresses; range r at slice [r*FLASH_ADDR_W +: FLASH_ADDR_W].
- range_end  out  NUM_RANGES*FLASH_ADDR_W  committed end addresses, same slicing.
- range_enable  out  NUM_RANGES  committed RANGE_EN register.
- range_flash_select  out  NUM_RANGES  committed RANGE_SEL register (0 = main, 1 = secondary).
- control_reg  out  8  committed CTRL: [1:0] mode, [2] host_select, [7:3] reserved.
- status_reg  out  8  live STATUS.
- cfg_update  out  1  one-cycle pulse when a commit changes the committed set.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Register map, byte addresses:
  - Range r start bytes (MSB first) at r*2*NB .. r*2*NB+NB-1.
  - Range r end bytes at r*2*NB+NB .. r*2*NB+2*NB-1.
  - With B = 2*NB*NUM_RANGES: CTRL = B, RANGE_EN = B+1, RANGE_SEL = B+2, STATUS = B+3 (read-only).
  - All other addresses are unmapped: reads return 0xFF, writes are ignored and set the error bit.
- Reset values:
  - Range registers (shadow and committed) all-ones.
  - CTRL, RANGE_EN, RANGE_SEL = 0; STATUS = 0.
  - mgmt_miso = 0, cfg_update = 0, FSM in IDLE, bit counter 0.
- Front end:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Rise, fall and cs_assert/cs_release strobes come from the last stage vs the previous stage.
  - A rise strobe shifts the MOSI sample in; a byte completes on the 8th rise.
- FSM (transitions on byte completion unless noted):
  - IDLE -> CMD on cs_assert.
  - CMD: opcode 0x02 -> ADDR (write); 0x03 -> ADDR (read); any other opcode -> IGNORE.
  - ADDR: load the 8-bit address pointer; go to WDATA for writes or RDATA for reads.
  - WDATA: each byte writes shadow[ptr], sets pending, then ptr <= ptr+1 (8-bit wrap, 0xFF -> 0x00). A write to STATUS or an unmapped address sets err.
  - RDATA:
    - On ADDR/RDATA byte completion, miso_sr <= reg[ptr] (committed view; STATUS reads live), then ptr++.
    - Each fall strobe: mgmt_miso <= miso_sr[7], miso_sr <= miso_sr<<1. The first bit is driven on the fall after the address byte's last rise.
    - Reading STATUS clears err after the byte is loaded.
  - IGNORE: no action; mgmt_miso held 0.
  - Any state -> IDLE on cs_release. The partial byte is discarded; already-completed bytes stay staged.
- Commit:
  - On cs_release with pending=1, all shadow registers copy to committed in a single clk edge; cfg_update pulses on the same edge; pending clears.
  - Latency from the mgmt_cs_n pin rising to outputs changing is SYNC_STAGES+1 clk.
  - A transaction with no WDATA bytes produces no commit and no pulse.
- mgmt_miso is 0 whenever the FSM is not in RDATA or CS is released.
- STATUS bits:
  - [0] cs active (synchronised).
  - [1] current command is read.
  - [2] current command is write.
  - [3] pending, i.e. staged writes not yet committed.
  - [4] err, sticky.
  - [7:5] = 0.
  - Bits [1] and [2] clear on cs_release.
- Simultaneous events:
  - cs_release in the same cycle as a rise strobe: release wins and the bit is dropped.
  - Async rst mid-transaction aborts everything and discards staged data.

Decomposition:
- Shared package spi_cfg_pkg holds:
  - Opcodes CMD_WRITE = 8'h02, CMD_READ = 8'h03.
  - The FSM state enum.
  - STATUS bit indices and CTRL field positions.
  - Functions for register offsets (range_start_addr, range_end_addr, ctrl_addr) as functions of NUM_RANGES and NB.
- One sub-module, spi_pin_sync: the synchroniser plus rise/fall/cs_assert/cs_release strobe generator.

Test Plan (NUM_RANGES=2, FLASH_ADDR_W=24, so CTRL=0x0C, RANGE_EN=0x0D, RANGE_SEL=0x0E, STATUS=0x0F):
- Reset -> range_start/range_end all 0xFFFFFF; control_reg=0; mgmt_miso=0; reading STATUS returns 0x01 (cs active during the read).
- Burst write 02 06 12 34 56 AB CD EF, then CS high -> the range1 slice of range_start=0x123456 and range_end=0xABCDEF both change on the same clk edge; cfg_update is one pulse SYNC_STAGES+1 clk after CS rises; the outputs were unchanged before CS release.
- Burst read 03 0C with 4 dummy bytes after writing CTRL=0x05, RANGE_EN=0x03 -> MISO bytes 05 03 00 01 (the last is STATUS with cs active).
- Write 02 0F 55 (write to STATUS) -> status_reg[4]=1; then read 03 0F -> returns 0x11; a subsequent read returns 0x01.
- Opcode 0x9F followed by 3 bytes -> mgmt_miso stays 0; no register changes; no cfg_update.
- Write 02 00 AA, then CS high after 5 bits of the next byte; and separately assert rst mid-burst -> first case commits 0xAA only; second case outputs are at reset values with no commit.
